// File: rtl/rv32i_hazard_ctrl.sv
// rv32i_hazard_ctrl: EX-stage forwarding selects, load-use bubble and
// branch-redirect flush sequencing, with saturating stall/flush counters.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   hz_id_src{1,2}_inx_i      rs1/rs2 of the instruction in ID
//   hz_ex_src{1,2}_inx_i      rs1/rs2 of the instruction in EX
//   hz_ex_rd_inx_i            rd of the instruction in EX
//   hz_ex_RegW_EN_i           EX instruction writes rd
//   hz_ex_is_lw_i             EX instruction is a load
//   hz_mem_br_taken_i         taken branch/jump now in MEM
//   hz_src{1,2}_sel_o         EX operand select: 00 RF, 11 MEM, 10 WB
//   hz_stall_{if,id}_o        hold PC / IF-ID
//   hz_flush_{id,ex,mem}_o    clear IF-ID / ID-EX / EX-MEM
//   hz_{stall,flush}_cnt_o    saturating event counters
module rv32i_hazard_ctrl #(
   parameter int REG_INX_WTH  = 5,
   parameter int FORW_MUX_WTH = 2,
   parameter int CNT_WTH      = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [REG_INX_WTH-1:0]  hz_id_src1_inx_i,
   input  logic [REG_INX_WTH-1:0]  hz_id_src2_inx_i,
   input  logic [REG_INX_WTH-1:0]  hz_ex_src1_inx_i,
   input  logic [REG_INX_WTH-1:0]  hz_ex_src2_inx_i,
   input  logic [REG_INX_WTH-1:0]  hz_ex_rd_inx_i,
   input  logic                    hz_ex_RegW_EN_i,
   input  logic                    hz_ex_is_lw_i,
   input  logic                    hz_mem_br_taken_i,
   output logic [FORW_MUX_WTH-1:0] hz_src1_sel_o,
   output logic [FORW_MUX_WTH-1:0] hz_src2_sel_o,
   output logic                    hz_stall_if_o,
   output logic                    hz_stall_id_o,
   output logic                    hz_flush_id_o,
   output logic                    hz_flush_ex_o,
   output logic                    hz_flush_mem_o,
   output logic [CNT_WTH-1:0]      hz_stall_cnt_o,
   output logic [CNT_WTH-1:0]      hz_flush_cnt_o
);

   typedef enum logic [1:0] {S_RUN, S_LU, S_REDIR} state_e;

   localparam logic [FORW_MUX_WTH-1:0] SEL_RF  = '0;
   localparam logic [FORW_MUX_WTH-1:0] SEL_MEM = FORW_MUX_WTH'(3);
   localparam logic [FORW_MUX_WTH-1:0] SEL_WB  = FORW_MUX_WTH'(2);

   state_e                 state_q, state_d;
   logic [REG_INX_WTH-1:0] mem_rd_q, wb_rd_q;
   logic                   mem_we_q, mem_lw_q, wb_we_q;
   logic [CNT_WTH-1:0]     stall_cnt_q, stall_cnt_d;
   logic [CNT_WTH-1:0]     flush_cnt_q, flush_cnt_d;
   logic                   lu_hit, br_fire, lu_fire;

   // A load sitting in MEM only holds its address, so it never forwards.
   function automatic logic [FORW_MUX_WTH-1:0] fwd_sel(
      input logic [REG_INX_WTH-1:0] src,
      input logic [REG_INX_WTH-1:0] m_rd,
      input logic                   m_we,
      input logic                   m_lw,
      input logic [REG_INX_WTH-1:0] w_rd,
      input logic                   w_we
   );
      logic [FORW_MUX_WTH-1:0] s;
      s = SEL_RF;
      if (src == '0)                           s = SEL_RF;
      else if (m_we && m_rd == src && !m_lw)   s = SEL_MEM;
      else if (w_we && w_rd == src)            s = SEL_WB;
      return s;
   endfunction

   always_comb begin
      lu_hit = hz_ex_is_lw_i && hz_ex_RegW_EN_i
               && (hz_ex_rd_inx_i != '0)
               && ((hz_ex_rd_inx_i == hz_id_src1_inx_i)
                   || (hz_ex_rd_inx_i == hz_id_src2_inx_i));
      br_fire = !rst && (state_q == S_RUN) && hz_mem_br_taken_i;
      lu_fire = !rst && (state_q == S_RUN) && !hz_mem_br_taken_i && lu_hit;

      state_d = state_q;
      unique case (state_q)
         S_RUN: begin
            if (hz_mem_br_taken_i) state_d = S_REDIR;
            else if (lu_hit)       state_d = S_LU;
         end
         S_LU:    state_d = S_RUN;
         S_REDIR: state_d = S_RUN;
         default: state_d = S_RUN;
      endcase

      hz_stall_if_o  = lu_fire;
      hz_stall_id_o  = lu_fire;
      hz_flush_id_o  = br_fire;
      hz_flush_ex_o  = br_fire || lu_fire;
      hz_flush_mem_o = br_fire;

      hz_src1_sel_o = SEL_RF;
      hz_src2_sel_o = SEL_RF;
      if (!rst) begin
         hz_src1_sel_o = fwd_sel(hz_ex_src1_inx_i, mem_rd_q, mem_we_q,
                                 mem_lw_q, wb_rd_q, wb_we_q);
         hz_src2_sel_o = fwd_sel(hz_ex_src2_inx_i, mem_rd_q, mem_we_q,
                                 mem_lw_q, wb_rd_q, wb_we_q);
      end

      stall_cnt_d = stall_cnt_q;
      if (lu_fire && stall_cnt_q != '1)
         stall_cnt_d = stall_cnt_q + CNT_WTH'(1);
      flush_cnt_d = flush_cnt_q;
      if (br_fire && flush_cnt_q != '1)
         flush_cnt_d = flush_cnt_q + CNT_WTH'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_RUN;
         mem_rd_q    <= '0;
         mem_we_q    <= 1'b0;
         mem_lw_q    <= 1'b0;
         wb_rd_q     <= '0;
         wb_we_q     <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         mem_rd_q    <= hz_ex_rd_inx_i;
         // The flushed EX instruction must not appear as a writer.
         mem_we_q    <= hz_flush_mem_o ? 1'b0 : hz_ex_RegW_EN_i;
         mem_lw_q    <= hz_flush_mem_o ? 1'b0 : hz_ex_is_lw_i;
         wb_rd_q     <= mem_rd_q;
         wb_we_q     <= mem_we_q;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign hz_stall_cnt_o = stall_cnt_q;
   assign hz_flush_cnt_o = flush_cnt_q;

endmodule
